// File: rtl/delay_window_pkg.sv
// Shared types for the delay-column window: per-beat action decode and the
// flag bundle produced by the position counters.
package delay_window_pkg;

    // What the window and counters do in a given cycle
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_CLEAR = 2'd2
    } win_act_t;

    // Per-beat flags presented alongside the window
    typedef struct packed {
        logic val;
        logic eol;
        logic eof;
    } win_flags_t;

    localparam win_flags_t FLAGS_IDLE = '0;

    // A configuration load overrides a column beat arriving in the same cycle
    function automatic win_act_t decode_act(input logic set, input logic beat);
        if (set) begin
            return ACT_CLEAR;
        end
        if (beat) begin
            return ACT_SHIFT;
        end
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/delay_window_cnt.sv
// Column/row position tracker for the delay-column stream. Holds the
// registered frame geometry, advances per accepted beat and produces the
// registered window-valid, end-of-row and end-of-frame flags.
module delay_window_cnt
    import delay_window_pkg::*;
#(
    parameter int CNT_WIDTH = 12,
    parameter int WIDTH_NB  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] cfg_cols,
    input  logic [CNT_WIDTH-1:0] cfg_rows,
    input  logic                 cfg_set,
    input  logic                 beat_val,
    output logic                 win_val,
    output logic                 win_eol,
    output logic                 win_eof
);

    // First column index at which the window holds WIDTH_NB columns of one row
    localparam logic [CNT_WIDTH-1:0] FIRST_FULL = CNT_WIDTH'(WIDTH_NB - 1);

    win_act_t             act;
    logic [CNT_WIDTH-1:0] cfg_cols_q, cfg_cols_d;
    logic [CNT_WIDTH-1:0] cfg_rows_q, cfg_rows_d;
    logic [CNT_WIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
    win_flags_t           flags_q, flags_d;
    logic                 last_col;
    logic                 last_row;

    assign act      = decode_act(cfg_set, beat_val);
    assign last_col = (col_cnt_q == cfg_cols_q);
    assign last_row = (row_cnt_q == cfg_rows_q);

    // Next geometry, position and flags for the current beat
    always_comb begin
        cfg_cols_d = cfg_cols_q;
        cfg_rows_d = cfg_rows_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        flags_d    = FLAGS_IDLE;
        case (act)
            ACT_CLEAR: begin
                cfg_cols_d = cfg_cols;
                cfg_rows_d = cfg_rows;
                col_cnt_d  = '0;
                row_cnt_d  = '0;
            end
            ACT_SHIFT: begin
                flags_d.val = (col_cnt_q >= FIRST_FULL);
                flags_d.eol = last_col;
                flags_d.eof = last_col && last_row;
                if (last_col) begin
                    col_cnt_d = '0;
                    row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
                end else begin
                    col_cnt_d = col_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Position, geometry and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cols_q <= '0;
            cfg_rows_q <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            flags_q    <= FLAGS_IDLE;
        end else begin
            cfg_cols_q <= cfg_cols_d;
            cfg_rows_q <= cfg_rows_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            flags_q    <= flags_d;
        end
    end

    assign win_val = flags_q.val;
    assign win_eol = flags_q.eol;
    assign win_eof = flags_q.eof;

endmodule

// File: rtl/delay_window.sv
// Consumer end of the delay column stream: shifts HEIGHT_NB-pixel columns
// into a WIDTH_NB-column window (w=0 newest) and flags complete windows,
// end of row and end of frame.
module delay_window
    import delay_window_pkg::*;
#(
    parameter int HEIGHT_NB = 3,
    parameter int WIDTH_NB  = 3,
    parameter int IMG_WIDTH = 8,
    parameter int CNT_WIDTH = 12
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CNT_WIDTH-1:0]                  cfg_cols,
    input  logic [CNT_WIDTH-1:0]                  cfg_rows,
    input  logic                                  cfg_set,
    input  logic [IMG_WIDTH*HEIGHT_NB-1:0]        delay_bus,
    input  logic                                  delay_val,
    output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] win_bus,
    output logic                                  win_val,
    output logic                                  win_eol,
    output logic                                  win_eof
);

    localparam int COL_W = IMG_WIDTH * HEIGHT_NB;
    localparam int WIN_W = COL_W * WIDTH_NB;

    win_act_t act;

    assign act = decode_act(cfg_set, delay_val);

    generate
        for (genvar w = 0; w < WIDTH_NB; w++) begin : g_col
            logic [COL_W-1:0] shift_in;
            logic [COL_W-1:0] col_q, col_d;

            // Newest column comes from the stream, older ones from the neighbour
            if (w == 0) begin : g_head
                assign shift_in = delay_bus;
            end else begin : g_tail
                assign shift_in = win_bus[(w-1)*COL_W +: COL_W];
            end

            // Column contents: clear on reconfigure, shift on beat, else hold
            always_comb begin
                col_d = col_q;
                case (act)
                    ACT_CLEAR: col_d = '0;
                    ACT_SHIFT: col_d = shift_in;
                    default:   ;
                endcase
            end

            // Column register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    col_q <= '0;
                end else begin
                    col_q <= col_d;
                end
            end

            assign win_bus[w*COL_W +: COL_W] = col_q;
        end
    endgenerate

    delay_window_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .WIDTH_NB  (WIDTH_NB)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_cols (cfg_cols),
        .cfg_rows (cfg_rows),
        .cfg_set  (cfg_set),
        .beat_val (delay_val),
        .win_val  (win_val),
        .win_eol  (win_eol),
        .win_eof  (win_eof)
    );

    // Window width is fixed by the parameters; keep the relation explicit
    if (WIN_W != COL_W * WIDTH_NB) begin : g_bad_width
        $error("delay_window: window width mismatch");
    end

endmodule

// File: tb/tb_delay_window.sv
// Directed bench for delay_window with default parameters (3x3 window,
// 8-bit pixels, 12-bit counters).
module tb_delay_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cfg_cols = '0;
    logic [11:0] cfg_rows = '0;
    logic        cfg_set = 1'b0;
    logic [23:0] delay_bus = '0;
    logic        delay_val = 1'b0;
    logic [71:0] win_bus;
    logic        win_val;
    logic        win_eol;
    logic        win_eof;

    int          n_vec = 0;
    int          n_err = 0;
    logic [71:0] exp_bus;

    always #5 clk = ~clk;

    delay_window dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .cfg_set   (cfg_set),
        .delay_bus (delay_bus),
        .delay_val (delay_val),
        .win_bus   (win_bus),
        .win_val   (win_val),
        .win_eol   (win_eol),
        .win_eof   (win_eof)
    );

    // Column for stream index i: pixel h = i*16 + h
    function automatic logic [23:0] mkcol(input int i);
        logic [23:0] c;
        for (int h = 0; h < 3; h++) begin
            c[h*8 +: 8] = 8'(i * 16 + h);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fl(input string tag, input logic [2:0] exp);
        chk(tag, {69'd0, win_val, win_eol, win_eof}, {69'd0, exp});
    endtask

    task automatic beat(input logic [23:0] d);
        @(negedge clk);
        delay_bus = d;
        delay_val = 1'b1;
        @(posedge clk);
        #1;
        delay_val = 1'b0;
        exp_bus = {exp_bus[47:0], d};
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [11:0] c, input logic [11:0] r, input logic dv, input logic [23:0] d);
        @(negedge clk);
        cfg_cols  = c;
        cfg_rows  = r;
        cfg_set   = 1'b1;
        delay_val = dv;
        delay_bus = d;
        @(posedge clk);
        #1;
        cfg_set   = 1'b0;
        delay_val = 1'b0;
        exp_bus   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_bus = '0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #10;
        chk("rst_bus", win_bus, 72'd0);
        chk_fl("rst_flags", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Geometry registers reset to 0: every beat is last column of last row
        beat(mkcol(1));
        chk_fl("rstcfg_flags", 3'b011);
        chk("rstcfg_bus", win_bus, {48'd0, mkcol(1)});

        // Back-to-back stream, 8 columns x 2 rows; cfg inputs then disturbed
        cfg(12'd7, 12'd1, 1'b0, 24'd0);
        chk_fl("t2_cfg_flags", 3'b000);
        chk("t2_cfg_bus", win_bus, 72'd0);
        cfg_cols = 12'd3;
        cfg_rows = 12'd0;
        for (int i = 0; i < 16; i++) begin
            beat(mkcol(i));
            chk_fl($sformatf("t2_flags_%0d", i),
                   {((i % 8) >= 2), ((i % 8) == 7), (i == 15)});
            if ((i % 8) >= 2) begin
                chk($sformatf("t2_bus_%0d", i), win_bus,
                    {mkcol(i - 2), mkcol(i - 1), mkcol(i)});
            end
        end

        // Same stream with idle cycles between beats
        cfg(12'd7, 12'd1, 1'b0, 24'd0);
        for (int i = 0; i < 16; i++) begin
            beat(mkcol(i));
            chk_fl($sformatf("t3_flags_%0d", i),
                   {((i % 8) >= 2), ((i % 8) == 7), (i == 15)});
            chk($sformatf("t3_bus_%0d", i), win_bus, exp_bus);
            idle();
            chk_fl($sformatf("t3_idle_flags_%0d", i), 3'b000);
            chk($sformatf("t3_idle_bus_%0d", i), win_bus, exp_bus);
        end

        // Narrow image, two columns per row: never a full window
        cfg(12'd1, 12'd1, 1'b0, 24'd0);
        for (int i = 0; i < 6; i++) begin
            beat(mkcol(i));
            chk_fl($sformatf("t4_flags_%0d", i), {1'b0, ((i % 2) == 1), (i == 3)});
        end

        // Reconfigure colliding with a beat: beat dropped, row restarts
        cfg(12'd7, 12'd1, 1'b0, 24'd0);
        for (int i = 0; i < 5; i++) begin
            beat(mkcol(i));
        end
        chk_fl("t5_pre_flags", 3'b100);
        cfg(12'd7, 12'd1, 1'b1, mkcol(5));
        chk_fl("t5_drop_flags", 3'b000);
        chk("t5_drop_bus", win_bus, 72'd0);
        for (int j = 0; j < 3; j++) begin
            beat(mkcol(20 + j));
            chk_fl($sformatf("t5_flags_%0d", j), {(j == 2), 1'b0, 1'b0});
        end
        chk("t5_bus", win_bus, {mkcol(20), mkcol(21), mkcol(22)});

        // Asynchronous reset in the middle of a stream
        beat(mkcol(23));
        @(negedge clk);
        delay_bus = mkcol(24);
        delay_val = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("t1_async_bus", win_bus, 72'd0);
        chk_fl("t1_async_flags", 3'b000);
        @(posedge clk);
        #1;
        chk("t1_held_bus", win_bus, 72'd0);
        chk_fl("t1_held_flags", 3'b000);
        @(negedge clk);
        rst_n     = 1'b1;
        delay_val = 1'b0;

        // Single-row frames of four columns: every row ends the frame
        cfg(12'd3, 12'd0, 1'b0, 24'd0);
        for (int i = 0; i < 8; i++) begin
            beat(mkcol(i + 2));
            chk_fl($sformatf("t6_flags_%0d", i),
                   {((i % 4) >= 2), ((i % 4) == 3), ((i % 4) == 3)});
            if ((i % 4) >= 2) begin
                chk($sformatf("t6_bus_%0d", i), win_bus,
                    {mkcol(i), mkcol(i + 1), mkcol(i + 2)});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
